// File: rtl/mu0_scan_reader.sv
// Debugger-side scan master: clocks the MU0 register scan path and returns a parallel acc/pc/flags snapshot.
// Optional MU0_SCAN_READER_REPEAT_EN: start held in DONE chains straight into the next snapshot.
module mu0_scan_reader #(
  parameter int CLK_DIV = 2,
  parameter int ACC_W   = 16,
  parameter int PC_W    = 12,
  parameter int FLAG_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              valid,
  output logic [ACC_W-1:0]  acc_q,
  output logic [PC_W-1:0]   pc_q,
  output logic [FLAG_W-1:0] flags_q,
  output logic              scan_clk,
  output logic              scan_en,
  input  logic              scan_in
);

  localparam int NBITS = ACC_W + PC_W + FLAG_W;
  localparam int BIT_W = $clog2(NBITS);
  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    IDLE, SYNC_LO, SYNC_HI, SHIFT_LO, SHIFT_HI, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic [ACC_W-1:0]   acc_d;
  logic [PC_W-1:0]    pc_d;
  logic [FLAG_W-1:0]  flags_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               scan_clk_q, scan_clk_d;
  logic               scan_en_q, scan_en_d;
  logic               phase_end;

  assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    valid_d = 1'b0;

    // Every timed phase shares one divider that restarts on each phase boundary.
    if (state_q == IDLE || state_q == DONE) div_d = '0;
    else if (phase_end)                     div_d = '0;
    else                                    div_d = div_q + DIV_W'(1);

    case (state_q)
      IDLE:    if (start) state_d = SYNC_LO;
      SYNC_LO: if (phase_end) state_d = SYNC_HI;
      SYNC_HI: if (phase_end) begin
        state_d = SHIFT_LO;
        bit_d   = '0;
      end
      SHIFT_LO: if (phase_end) begin
        // Sample at the end of the low phase so the scanner has settled since the last rise.
        shift_d[bit_q] = scan_in;
        if (bit_q == BIT_W'(NBITS - 1)) begin
          state_d = DONE;
          acc_d   = shift_d[ACC_W-1:0];
          pc_d    = shift_d[ACC_W +: PC_W];
          flags_d = shift_d[NBITS-1 -: FLAG_W];
          valid_d = 1'b1;
        end else begin
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: if (phase_end) begin
        state_d = SHIFT_LO;
        bit_d   = bit_q + BIT_W'(1);
      end
      DONE: begin
`ifdef MU0_SCAN_READER_REPEAT_EN
        state_d = start ? SYNC_LO : IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    scan_clk_d = (state_d == SYNC_HI) || (state_d == SHIFT_HI);
    scan_en_d  = (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      acc_q      <= '0;
      pc_q       <= '0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      scan_clk_q <= 1'b0;
      scan_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      pc_q       <= pc_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      scan_clk_q <= scan_clk_d;
      scan_en_q  <= scan_en_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign scan_clk = scan_clk_q;
  assign scan_en  = scan_en_q;

endmodule

// File: tb/tb_mu0_scan_reader.sv
// Directed bench for mu0_scan_reader: two instances (CLK_DIV=2 and 1), each driving a behavioural MU0 scanner.
module tb_mu0_scan_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic        busy0, valid0, sclk0, sen0, sin0;
  logic        busy1, valid1, sclk1, sen1, sin1;
  logic [15:0] acc0, acc1;
  logic [11:0] pc0, pc1;
  logic [1:0]  fl0, fl1;

  mu0_scan_reader #(.CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .valid(valid0),
    .acc_q(acc0), .pc_q(pc0), .flags_q(fl0),
    .scan_clk(sclk0), .scan_en(sen0), .scan_in(sin0)
  );

  mu0_scan_reader #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .valid(valid1),
    .acc_q(acc1), .pc_q(pc1), .flags_q(fl1),
    .scan_clk(sclk1), .scan_en(sen1), .scan_in(sin1)
  );

  // Scanner model: rise with scan_en clears the bit pointer when low, advances it when high.
  logic [31:0] src0 = '0, src1 = '0;
  logic [4:0]  cnt0, cnt1;
  logic        stray_clk = 1'b0, stray_en = 1'b0;
  wire         sck0 = sclk0 | stray_clk;
  wire         sen_s0 = sen0 | stray_en;

  always @(posedge sck0) cnt0 <= sen_s0 ? cnt0 + 5'd1 : 5'd0;
  always @(posedge sclk1) cnt1 <= sen1 ? cnt1 + 5'd1 : 5'd0;
  assign sin0 = src0[cnt0];
  assign sin1 = src1[cnt1];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int   nvalid;
  bit   busy_gap;
  logic sc_hist [0:7];

  // Pulse start on one instance, then watch 200 cycles; cyc = first valid cycle (start cycle = 0).
  task automatic snap(input bit d1, input int ra, input int rb, output int cyc);
    int c;
    @(negedge clk);
    if (d1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    c = 1; cyc = -1; nvalid = 0; busy_gap = 0;
    while (c < 200) begin
      if (c < 8) sc_hist[c] = d1 ? sclk1 : sclk0;
      if (d1 ? valid1 : valid0) begin
        nvalid++;
        if (cyc < 0) cyc = c;
      end
      if (cyc < 0 && !(d1 ? busy1 : busy0)) busy_gap = 1;
      if (d1) start1 = (c == ra || c == rb);
      else    start0 = (c == ra || c == rb);
      @(posedge clk); #1;
      c++;
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  int cyc, v1, v2, low_between;
  logic [15:0] a1, a2;
  bit saw_valid;

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_sclk_sen", {sclk0, sen0}, 0);
    chk("rst_outs", {acc0, pc0, fl0}, 0);
    chk("rst_busy1", busy1, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: default divider
    src0 = {2'b00, 2'b10, 12'h7E1, 16'hA5C3};
    snap(0, -1, -1, cyc);
    chk("t1_lat", cyc, 123);
    chk("t1_acc", acc0, 16'hA5C3);
    chk("t1_pc", pc0, 12'h7E1);
    chk("t1_flags", fl0, 2'b10);
    chk("t1_nvalid", nvalid, 1);
    chk("t1_idle", busy0, 0);

    // 2: CLK_DIV=1
    src1 = {2'b00, 2'b01, 12'h000, 16'hFFFF};
    snap(1, -1, -1, cyc);
    chk("t2_lat", cyc, 62);
    chk("t2_outs", {acc1, pc1, fl1}, {16'hFFFF, 12'h000, 2'b01});
    chk("t2_sclk", {sc_hist[1], sc_hist[2], sc_hist[3], sc_hist[4], sc_hist[5]}, 5'b01010);

    // 3: start re-pulsed while busy
    src0 = {2'b00, 2'b11, 12'hABC, 16'h1234};
    snap(0, 10, 50, cyc);
    chk("t3_nvalid", nvalid, 1);
    chk("t3_busy_gap", busy_gap, 0);
    chk("t3_lat", cyc, 123);
    chk("t3_outs", {acc0, pc0, fl0}, {16'h1234, 12'hABC, 2'b11});

    // 4: reset mid-scan at cycle 40
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (39) begin @(posedge clk); #1; end
    chk("t4_pre_busy", {busy0, sen0}, 2'b11);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t4_sclk_sen_busy", {sclk0, sen0, busy0}, 3'b000);
    chk("t4_outs", {acc0, pc0, fl0}, 0);
    rst_n = 1'b1;
    saw_valid = 0;
    repeat (150) begin @(posedge clk); #1; if (valid0) saw_valid = 1; end
    chk("t4_no_valid", saw_valid, 0);
    src0 = {2'b00, 2'b01, 12'h0F0, 16'h0F0F};
    snap(0, -1, -1, cyc);
    chk("t4_restart_lat", cyc, 123);
    chk("t4_restart_outs", {acc0, pc0, fl0}, {16'h0F0F, 12'h0F0, 2'b01});

    // 5: start held high, acc changes between snapshots
    src0 = {2'b00, 2'b00, 12'h000, 16'h0001};
    v1 = -1; v2 = -1; low_between = 0; a1 = '0; a2 = '0;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c < 400 && v2 < 0; c++) begin
      if (valid0) begin
        if (v1 < 0) begin
          v1 = c; a1 = acc0;
          src0 = {2'b00, 2'b00, 12'h000, 16'h0002};
        end else begin
          v2 = c; a2 = acc0;
          start0 = 1'b0;
        end
      end else if (v1 >= 0 && !busy0) begin
        low_between++;
      end
      if (v2 < 0) begin @(posedge clk); #1; end
    end
    start0 = 1'b0;
    chk("t5_first_lat", v1, 123);
    chk("t5_acc_first", a1, 16'h0001);
    chk("t5_acc_second", a2, 16'h0002);
`ifdef MU0_SCAN_READER_REPEAT_EN
    chk("t5_period", v2 - v1, 123);
    chk("t5_busy_low", low_between, 0);
`else
    chk("t5_period", v2 - v1, 124);
    chk("t5_busy_low", low_between, 1);
`endif
    repeat (5) begin @(posedge clk); #1; end
    chk("t5_idle", busy0, 0);

    // 6: scanner pointer knocked to 17 by stray clocks while idle
    #1 stray_clk = 1'b1; #1 stray_clk = 1'b0;
    #1 stray_en = 1'b1;
    repeat (17) begin #1 stray_clk = 1'b1; #1 stray_clk = 1'b0; end
    #1 stray_en = 1'b0;
    chk("t6_stray_ptr", cnt0, 5'd17);
    src0 = {2'b00, 2'b01, 12'h555, 16'h8001};
    snap(0, -1, -1, cyc);
    chk("t6_lat", cyc, 123);
    chk("t6_outs", {acc0, pc0, fl0}, {16'h8001, 12'h555, 2'b01});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
